// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative shift-add
// multiplier, branch compare, and the execute/memory pipeline register.
//
// state  | meaning
// S_IDLE | no multiply in flight; a mul presented here is latched and stalls
// S_BUSY | shift-add iterations, one multiplier bit per cycle
// S_DONE | accumulator holds the product; E/M captures it this edge
module execute_stage #(
  parameter int N = 32,
  parameter int M = 4,
  parameter int L = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_M,
  input  logic         regw_E,
  input  logic         memw_E,
  input  logic         regmem_E,
  input  logic         ALUope_E,
  input  logic         branch_E,
  input  logic [4:0]   op_code_E,
  input  logic [L-1:0] ALUctrl_E,
  input  logic [M-1:0] regScr_E,
  input  logic [M-1:0] regAE,
  input  logic [M-1:0] regBE,
  input  logic [N-1:0] regA_E,
  input  logic [N-1:0] regB_E,
  input  logic [N-1:0] inm_E,
  input  logic         regw_M_i,
  input  logic [M-1:0] regScr_M_i,
  input  logic [N-1:0] ALUres_M_i,
  input  logic         regw_W,
  input  logic [M-1:0] regScr_W,
  input  logic [N-1:0] result_W,
  output logic         stall_E,
  output logic         branch_taken_E,
  output logic [N-1:0] branch_target_E,
  output logic         regw_M,
  output logic         memw_M,
  output logic         regmem_M,
  output logic [4:0]   op_code_M,
  output logic [M-1:0] regScr_M,
  output logic [N-1:0] ALUres_M,
  output logic [N-1:0] wdata_M
);

  localparam int CW = $clog2(N);

  localparam logic [L-1:0] OP_ADD = L'(0);
  localparam logic [L-1:0] OP_SUB = L'(1);
  localparam logic [L-1:0] OP_AND = L'(2);
  localparam logic [L-1:0] OP_OR  = L'(3);
  localparam logic [L-1:0] OP_XOR = L'(4);
  localparam logic [L-1:0] OP_SLL = L'(5);
  localparam logic [L-1:0] OP_SRL = L'(6);
  localparam logic [L-1:0] OP_MUL = L'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mul_state_t;

  mul_state_t    state;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplr;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;

  logic [N-1:0]  fwd_a;
  logic [N-1:0]  fwd_b;
  logic [N-1:0]  alu_b;
  logic [N-1:0]  alu_res;

  // M-stage result is newer than W, so it wins when both match
  always_comb begin
    fwd_a = regA_E;
    if (regw_M_i && (regScr_M_i == regAE))
      fwd_a = ALUres_M_i;
    else if (regw_W && (regScr_W == regAE))
      fwd_a = result_W;

    fwd_b = regB_E;
    if (regw_M_i && (regScr_M_i == regBE))
      fwd_b = ALUres_M_i;
    else if (regw_W && (regScr_W == regBE))
      fwd_b = result_W;
  end

  assign alu_b = ALUope_E ? inm_E : fwd_b;

  always_comb begin
    alu_res = '0;
    case (ALUctrl_E)
      OP_ADD:  alu_res = fwd_a + alu_b;
      OP_SUB:  alu_res = fwd_a - alu_b;
      OP_AND:  alu_res = fwd_a & alu_b;
      OP_OR:   alu_res = fwd_a | alu_b;
      OP_XOR:  alu_res = fwd_a ^ alu_b;
      OP_SLL:  alu_res = fwd_a << alu_b[4:0];
      OP_SRL:  alu_res = fwd_a >> alu_b[4:0];
      OP_MUL:  alu_res = acc;
      default: alu_res = '0;
    endcase
  end

  assign branch_taken_E  = branch_E & (fwd_a == fwd_b);
  assign branch_target_E = inm_E;

  // The latch cycle in IDLE must already stall, so this cannot be registered
  assign stall_E = (state == S_BUSY) ||
                   ((state == S_IDLE) && (ALUctrl_E == OP_MUL));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ALUctrl_E == OP_MUL) begin
            mcand <= fwd_a;
            mplr  <= alu_b;
            acc   <= '0;
            cnt   <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mplr[0])
            acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1))
            state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regw_M    <= 1'b0;
      memw_M    <= 1'b0;
      regmem_M  <= 1'b0;
      op_code_M <= '0;
      regScr_M  <= '0;
      ALUres_M  <= '0;
      wdata_M   <= '0;
    end else if (stall_E || flush_M) begin
      regw_M    <= 1'b0;
      memw_M    <= 1'b0;
      regmem_M  <= 1'b0;
      op_code_M <= '0;
      regScr_M  <= '0;
      ALUres_M  <= '0;
      wdata_M   <= '0;
    end else begin
      regw_M    <= regw_E;
      memw_M    <= memw_E;
      regmem_M  <= regmem_E;
      op_code_M <= op_code_E;
      regScr_M  <= regScr_E;
      ALUres_M  <= alu_res;
      wdata_M   <= fwd_b;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding, ALU ops, multiplier timing,
// branches, reset and flush behaviour.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        flush_M;
  logic        regw_E, memw_E, regmem_E, ALUope_E, branch_E;
  logic [4:0]  op_code_E;
  logic [2:0]  ALUctrl_E;
  logic [3:0]  regScr_E, regAE, regBE;
  logic [31:0] regA_E, regB_E, inm_E;
  logic        regw_M_i;
  logic [3:0]  regScr_M_i;
  logic [31:0] ALUres_M_i;
  logic        regw_W;
  logic [3:0]  regScr_W;
  logic [31:0] result_W;
  logic        stall_E, branch_taken_E;
  logic [31:0] branch_target_E;
  logic        regw_M, memw_M, regmem_M;
  logic [4:0]  op_code_M;
  logic [3:0]  regScr_M;
  logic [31:0] ALUres_M, wdata_M;

  int vectors;
  int miscompares;

  execute_stage #(.N(32), .M(4), .L(3)) dut (
    .clk(clk), .rst(rst), .flush_M(flush_M),
    .regw_E(regw_E), .memw_E(memw_E), .regmem_E(regmem_E),
    .ALUope_E(ALUope_E), .branch_E(branch_E),
    .op_code_E(op_code_E), .ALUctrl_E(ALUctrl_E),
    .regScr_E(regScr_E), .regAE(regAE), .regBE(regBE),
    .regA_E(regA_E), .regB_E(regB_E), .inm_E(inm_E),
    .regw_M_i(regw_M_i), .regScr_M_i(regScr_M_i), .ALUres_M_i(ALUres_M_i),
    .regw_W(regw_W), .regScr_W(regScr_W), .result_W(result_W),
    .stall_E(stall_E), .branch_taken_E(branch_taken_E),
    .branch_target_E(branch_target_E),
    .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M),
    .op_code_M(op_code_M), .regScr_M(regScr_M),
    .ALUres_M(ALUres_M), .wdata_M(wdata_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    flush_M = 0; regw_E = 0; memw_E = 0; regmem_E = 0; ALUope_E = 0; branch_E = 0;
    op_code_E = 0; ALUctrl_E = 0; regScr_E = 0; regAE = 4'd1; regBE = 4'd2;
    regA_E = 0; regB_E = 0; inm_E = 0;
    regw_M_i = 0; regScr_M_i = 4'd14; ALUres_M_i = 0;
    regw_W = 0; regScr_W = 4'd15; result_W = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    clear_inputs();
    #3;
    vectors++;
    if ({regw_M, memw_M, regmem_M, op_code_M, regScr_M, ALUres_M, wdata_M, stall_E} !== '0) begin
      miscompares++;
      $display("FAIL reset_initial: outputs=%h expected all zero",
               {regw_M, memw_M, regmem_M, op_code_M, regScr_M, ALUres_M, wdata_M, stall_E});
    end
    #9 rst = 1;
    regw_E = 1; memw_E = 1; regmem_E = 1; op_code_E = 5'h13; regScr_E = 4'd9;
    regA_E = 32'd5; regB_E = 32'd6; ALUctrl_E = 3'd0;
    tick();
    vectors++;
    if (ALUres_M !== 32'd11 || regw_M !== 1'b1 || op_code_M !== 5'h13) begin
      miscompares++;
      $display("FAIL reset_pre_add: ALUres_M=%h regw_M=%b op=%h expected 0000000b 1 13",
               ALUres_M, regw_M, op_code_M);
    end
    #2 rst = 0;
    #1;
    vectors++;
    if ({regw_M, memw_M, regmem_M, op_code_M, regScr_M, ALUres_M, wdata_M} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: outputs=%h expected all zero",
               {regw_M, memw_M, regmem_M, op_code_M, regScr_M, ALUres_M, wdata_M});
    end
    #2 rst = 1;
    clear_inputs();
    tick();
  endtask

  task automatic test_forwarding;
    clear_inputs();
    regw_E = 1; regmem_E = 1; op_code_E = 5'h0a; regScr_E = 4'd7;
    regAE = 4'd3; regBE = 4'd5; regA_E = 32'd1; regB_E = 32'd5;
    regw_M_i = 1; regScr_M_i = 4'd3; ALUres_M_i = 32'd10;
    tick();
    vectors++;
    if (ALUres_M !== 32'd15) begin
      miscompares++;
      $display("FAIL fwd_m_a: ALUres_M=%0d expected 15", ALUres_M);
    end
    vectors++;
    if (regScr_M !== 4'd7 || op_code_M !== 5'h0a || regmem_M !== 1'b1 || memw_M !== 1'b0 || wdata_M !== 32'd5) begin
      miscompares++;
      $display("FAIL fwd_passthru: regScr=%h op=%h regmem=%b memw=%b wdata=%h expected 7 0a 1 0 00000005",
               regScr_M, op_code_M, regmem_M, memw_M, wdata_M);
    end
    regw_W = 1; regScr_W = 4'd3; result_W = 32'd99;
    tick();
    vectors++;
    if (ALUres_M !== 32'd15) begin
      miscompares++;
      $display("FAIL fwd_m_priority: ALUres_M=%0d expected 15", ALUres_M);
    end
    regScr_M_i = 4'd8;
    tick();
    vectors++;
    if (ALUres_M !== 32'd104) begin
      miscompares++;
      $display("FAIL fwd_w_a: ALUres_M=%0d expected 104", ALUres_M);
    end
    regBE = 4'd3;
    tick();
    vectors++;
    if (ALUres_M !== 32'd198 || wdata_M !== 32'd99) begin
      miscompares++;
      $display("FAIL fwd_w_b: ALUres_M=%0d wdata_M=%0d expected 198 99", ALUres_M, wdata_M);
    end
    regAE = 4'd0; regScr_M_i = 4'd0; regBE = 4'd5;
    tick();
    vectors++;
    if (ALUres_M !== 32'd15) begin
      miscompares++;
      $display("FAIL fwd_index0: ALUres_M=%0d expected 15", ALUres_M);
    end
  endtask

  task automatic test_alu_ops;
    logic [31:0] exp_tab [7];
    exp_tab[0] = 32'h00E01237;
    exp_tab[1] = 32'hE1001231;
    exp_tab[2] = 32'h00F00000;
    exp_tab[3] = 32'hFFF01237;
    exp_tab[4] = 32'hFF001237;
    exp_tab[5] = 32'h878091A0;
    exp_tab[6] = 32'h1E1E0246;
    clear_inputs();
    regw_E = 1; regA_E = 32'hF0F01234; regB_E = 32'h0FF00003;
    for (int i = 0; i < 7; i++) begin
      ALUctrl_E = 3'(i);
      tick();
      vectors++;
      if (ALUres_M !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL alu_op%0d: ALUres_M=%h expected %h", i, ALUres_M, exp_tab[i]);
      end
    end
  endtask

  task automatic test_immediate;
    clear_inputs();
    regw_E = 1; ALUope_E = 1; regA_E = 32'hFFFFFFFF; inm_E = 32'd2; regB_E = 32'h55;
    tick();
    vectors++;
    if (ALUres_M !== 32'h00000001 || wdata_M !== 32'h55) begin
      miscompares++;
      $display("FAIL imm_wrap: ALUres_M=%h wdata_M=%h expected 00000001 00000055", ALUres_M, wdata_M);
    end
    regA_E = 32'h80000000; inm_E = 32'd4; ALUctrl_E = 3'd6;
    tick();
    vectors++;
    if (ALUres_M !== 32'h08000000) begin
      miscompares++;
      $display("FAIL imm_srl: ALUres_M=%h expected 08000000", ALUres_M);
    end
  endtask

  task automatic test_multiply(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expv, input int flush_at);
    int n;
    logic bubble_bad;
    clear_inputs();
    regw_E = 1; regScr_E = 4'd2; op_code_E = 5'h1c;
    regA_E = a; regB_E = b; ALUctrl_E = 3'd7;
    #1;
    n = 0;
    bubble_bad = 0;
    while (stall_E === 1'b1 && n < 40) begin
      if (n == flush_at) flush_M = 1;
      if (n == flush_at + 3) flush_M = 0;
      tick();
      n++;
      if (regw_M !== 1'b0 || ALUres_M !== 32'd0 || regScr_M !== 4'd0) bubble_bad = 1;
    end
    vectors++;
    if (n !== 33) begin
      miscompares++;
      $display("FAIL mul_stall_cycles: stall cycles=%0d expected 33", n);
    end
    vectors++;
    if (bubble_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_bubbles: non-bubble seen during stall=%b expected 0", bubble_bad);
    end
    tick();
    vectors++;
    if (ALUres_M !== expv || regw_M !== 1'b1 || regScr_M !== 4'd2) begin
      miscompares++;
      $display("FAIL mul_result: ALUres_M=%h regw_M=%b regScr_M=%h expected %h 1 2",
               ALUres_M, regw_M, regScr_M, expv);
    end
    ALUctrl_E = 3'd0;
    flush_M = 0;
  endtask

  task automatic test_branch;
    clear_inputs();
    branch_E = 1; regA_E = 32'd7; regB_E = 32'd7; inm_E = 32'h00000400;
    #1;
    vectors++;
    if (branch_taken_E !== 1'b1 || branch_target_E !== 32'h400) begin
      miscompares++;
      $display("FAIL branch_eq: taken=%b target=%h expected 1 00000400", branch_taken_E, branch_target_E);
    end
    regB_E = 32'd8;
    #1;
    vectors++;
    if (branch_taken_E !== 1'b0) begin
      miscompares++;
      $display("FAIL branch_ne: taken=%b expected 0", branch_taken_E);
    end
    regw_M_i = 1; regScr_M_i = 4'd1; ALUres_M_i = 32'd8;
    #1;
    vectors++;
    if (branch_taken_E !== 1'b1) begin
      miscompares++;
      $display("FAIL branch_fwd: taken=%b expected 1", branch_taken_E);
    end
    branch_E = 0;
    #1;
    vectors++;
    if (branch_taken_E !== 1'b0) begin
      miscompares++;
      $display("FAIL branch_off: taken=%b expected 0", branch_taken_E);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_mul;
    clear_inputs();
    regw_E = 1; regA_E = 32'd1234; regB_E = 32'd5678; ALUctrl_E = 3'd7;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (stall_E !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_busy: stall_E=%b expected 1", stall_E);
    end
    #2 rst = 0; ALUctrl_E = 3'd0;
    #1;
    vectors++;
    if (stall_E !== 1'b0 || {regw_M, op_code_M, regScr_M, ALUres_M, wdata_M} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: stall_E=%b outputs=%h expected 0 0",
               stall_E, {regw_M, op_code_M, regScr_M, ALUres_M, wdata_M});
    end
    tick();
    rst = 1;
    tick();
    test_multiply(32'd3, 32'd4, 32'd12, -10);
  endtask

  task automatic test_flush;
    clear_inputs();
    regw_E = 1; memw_E = 1; regScr_E = 4'd6; regA_E = 32'd1; regB_E = 32'd2; flush_M = 1;
    tick();
    vectors++;
    if (regw_M !== 1'b0 || memw_M !== 1'b0 || ALUres_M !== 32'd0 || regScr_M !== 4'd0) begin
      miscompares++;
      $display("FAIL flush_bubble: regw=%b memw=%b ALUres=%h regScr=%h expected 0 0 0 0",
               regw_M, memw_M, ALUres_M, regScr_M);
    end
    flush_M = 0;
    tick();
    vectors++;
    if (regw_M !== 1'b1 || ALUres_M !== 32'd3 || regScr_M !== 4'd6) begin
      miscompares++;
      $display("FAIL flush_release: regw=%b ALUres=%h regScr=%h expected 1 3 6",
               regw_M, ALUres_M, regScr_M);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_forwarding();
    test_alu_ops();
    test_immediate();
    test_branch();
    test_multiply(32'd1234, 32'd5678, 32'd7006652, -10);
    test_multiply(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, -10);
    test_reset_mid_mul();
    test_flush();
    test_multiply(32'd1234, 32'd5678, 32'd7006652, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
